// File: rtl/repeat_n_stream_pkg.sv
// Shared definitions for the repeat_n_stream primitive: FSM state encoding and
// the handshake helper used by the stream blocks.
package repeat_n_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_INF    = 2'd2
   } state_e;

   function automatic logic fire(input logic valid, input logic ready);
      return valid & ready;
   endfunction

endpackage

// File: rtl/repeat_n_stream_beat_counter.sv
// Beat bookkeeping for repeat_n_stream: remaining-beat count, 0-based beat index
// and the "one beat left" flag.
module repeat_n_stream_beat_counter #(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [COUNT_W-1:0] load_count,
   input  logic               step,
   input  logic               dec,
   output logic [COUNT_W-1:0] remaining,
   output logic [COUNT_W-1:0] idx,
   output logic               last_n
);

   logic [COUNT_W-1:0] remaining_r;
   logic [COUNT_W-1:0] idx_r;

   // A load wins over a step: the step retires the old stream's last beat
   // while the load starts the next one at index 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         remaining_r <= {COUNT_W{1'b0}};
         idx_r       <= {COUNT_W{1'b0}};
      end else if (load) begin
         remaining_r <= load_count;
         idx_r       <= {COUNT_W{1'b0}};
      end else if (step) begin
         idx_r <= idx_r + COUNT_W'(1'b1);
         if (dec) begin
            remaining_r <= remaining_r - COUNT_W'(1'b1);
         end else begin
            remaining_r <= remaining_r;
         end
      end else begin
         remaining_r <= remaining_r;
         idx_r       <= idx_r;
      end
   end

   // Drive the counter outputs and the one-beat-left flag.
   always_comb begin
      remaining = remaining_r;
      idx       = idx_r;
      last_n    = (remaining_r == COUNT_W'(1'b1));
   end

endmodule

// File: rtl/repeat_n_stream.sv
// Repeats an accepted (value, count) as a valid/ready beat stream with last flag
// and beat index; count==0 can mean an endless stream terminated by stop.
module repeat_n_stream
   import repeat_n_stream_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int COUNT_W      = 8,
   parameter int INF_ON_ZERO  = 1,
   parameter int BACK_TO_BACK = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_value,
   input  logic [COUNT_W-1:0] in_count,
   input  logic               stop,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_value,
   output logic               out_last,
   output logic [COUNT_W-1:0] out_idx
);

   state_e             state_r;
   state_e             state_nx_s;
   state_e             load_target_s;
   logic               out_valid_r;
   logic [WIDTH-1:0]   value_r;
   logic               accept_s;
   logic               fire_s;
   logic               end_s;
   logic               last_n_s;
   logic [COUNT_W-1:0] remaining_s;
   logic [COUNT_W-1:0] idx_s;

   repeat_n_stream_beat_counter #(
      .COUNT_W(COUNT_W)
   ) u_beat_counter (
      .clk       (clk),
      .rst       (rst),
      .load      (accept_s),
      .load_count(in_count),
      .step      (fire_s),
      .dec       (state_r == ST_STREAM),
      .remaining (remaining_s),
      .idx       (idx_s),
      .last_n    (last_n_s)
   );

   // State register; out_valid is registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         out_valid_r <= (state_nx_s != ST_IDLE);
      end
   end

   // Latched copy of the accepted value.
   always_ff @(posedge clk) begin
      if (rst) begin
         value_r <= {WIDTH{1'b0}};
      end else if (accept_s) begin
         value_r <= in_value;
      end else begin
         value_r <= value_r;
      end
   end

   // Next-state logic, including the back-to-back reload on the final beat.
   always_comb begin
      state_nx_s = state_r;
      if (in_count != {COUNT_W{1'b0}}) begin
         load_target_s = ST_STREAM;
      end else if (INF_ON_ZERO != 0) begin
         load_target_s = ST_INF;
      end else begin
         load_target_s = ST_IDLE;
      end
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nx_s = load_target_s;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_STREAM, ST_INF: begin
            if (end_s) begin
               state_nx_s = accept_s ? load_target_s : ST_IDLE;
            end else begin
               state_nx_s = state_r;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Handshake and stream outputs.
   always_comb begin
      out_valid = out_valid_r;
      out_value = value_r;
      out_idx   = idx_s;
      out_last  = out_valid_r & (stop | ((state_r == ST_STREAM) & last_n_s));
      fire_s    = fire(out_valid_r, out_ready);
      end_s     = fire_s & out_last;
      if (rst) begin
         in_ready = 1'b0;
      end else if (state_r == ST_IDLE) begin
         in_ready = 1'b1;
      end else if (BACK_TO_BACK != 0) begin
         in_ready = end_s;
      end else begin
         in_ready = 1'b0;
      end
      accept_s = in_valid & in_ready;
   end

   logic unused_s;
   assign unused_s = ^remaining_s;

endmodule

// File: tb/tb_repeat_n_stream.sv
// Directed self-checking bench for repeat_n_stream; a second instance with
// INF_ON_ZERO=0 shares the stimulus for the empty-stream case.
module tb_repeat_n_stream;

   logic       clk_s = 1'b0;
   logic       rst_s = 1'b1;
   logic       in_valid_s = 1'b0;
   logic [7:0] in_value_s = 8'd0;
   logic [7:0] in_count_s = 8'd0;
   logic       stop_s = 1'b0;
   logic       out_ready_s = 1'b0;

   logic       in_ready_s,  out_valid_s,  out_last_s;
   logic [7:0] out_value_s, out_idx_s;
   logic       in_ready0_s, out_valid0_s, out_last0_s;
   logic [7:0] out_value0_s, out_idx0_s;

   int checks = 0;
   int errors = 0;

   always #5 clk_s = ~clk_s;

   repeat_n_stream #(.WIDTH(8), .COUNT_W(8), .INF_ON_ZERO(1), .BACK_TO_BACK(1)) dut (
      .clk(clk_s), .rst(rst_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
      .in_value(in_value_s), .in_count(in_count_s), .stop(stop_s),
      .out_valid(out_valid_s), .out_ready(out_ready_s), .out_value(out_value_s),
      .out_last(out_last_s), .out_idx(out_idx_s));

   repeat_n_stream #(.WIDTH(8), .COUNT_W(8), .INF_ON_ZERO(0), .BACK_TO_BACK(1)) dut0 (
      .clk(clk_s), .rst(rst_s), .in_valid(in_valid_s), .in_ready(in_ready0_s),
      .in_value(in_value_s), .in_count(in_count_s), .stop(stop_s),
      .out_valid(out_valid0_s), .out_ready(out_ready_s), .out_value(out_value0_s),
      .out_last(out_last0_s), .out_idx(out_idx0_s));

   task automatic step();
      @(posedge clk_s);
      #1;
   endtask

   task automatic do_reset();
      rst_s = 1'b1; in_valid_s = 1'b0; stop_s = 1'b0; out_ready_s = 1'b0;
      step(); step();
      rst_s = 1'b0;
      #1;
   endtask

   task automatic offer(input logic [7:0] v, input logic [7:0] c);
      in_valid_s = 1'b1; in_value_s = v; in_count_s = c;
   endtask

   task automatic test_reset();
      rst_s = 1'b1; in_valid_s = 1'b1; out_ready_s = 1'b1;
      step(); step();
      checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid_s); end
      checks++; if (out_value_s !== 8'd0) begin errors++; $display("FAIL reset_value got %0d exp 0", out_value_s); end
      checks++; if (out_idx_s !== 8'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", out_idx_s); end
      checks++; if (in_ready_s !== 1'b0) begin errors++; $display("FAIL reset_in_ready_held got %b exp 0", in_ready_s); end
      in_valid_s = 1'b0; rst_s = 1'b0;
      #1;
      checks++; if (in_ready_s !== 1'b1) begin errors++; $display("FAIL reset_in_ready_release got %b exp 1", in_ready_s); end
   endtask

   task automatic test_basic();
      out_ready_s = 1'b1;
      offer(8'd42, 8'd3);
      step();
      in_valid_s = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (out_valid_s !== 1'b1) begin errors++; $display("FAIL t1_valid beat %0d got %b exp 1", i, out_valid_s); end
         checks++; if (out_value_s !== 8'd42) begin errors++; $display("FAIL t1_value beat %0d got %0d exp 42", i, out_value_s); end
         checks++; if (out_idx_s !== 8'(i)) begin errors++; $display("FAIL t1_idx got %0d exp %0d", out_idx_s, i); end
         checks++; if (out_last_s !== (i == 2)) begin errors++; $display("FAIL t1_last beat %0d got %b exp %b", i, out_last_s, (i == 2)); end
         step();
      end
      checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL t1_done_valid got %b exp 0", out_valid_s); end
      checks++; if (in_ready_s !== 1'b1) begin errors++; $display("FAIL t1_done_in_ready got %b exp 1", in_ready_s); end
   endtask

   task automatic test_infinite_stop();
      out_ready_s = 1'b1;
      offer(8'd7, 8'd0);
      step();
      in_valid_s = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++; if (out_valid_s !== 1'b1 || out_value_s !== 8'd7) begin errors++; $display("FAIL t2_beat %0d valid %b value %0d exp 1/7", i, out_valid_s, out_value_s); end
         checks++; if (out_last_s !== 1'b0 || out_idx_s !== 8'(i)) begin errors++; $display("FAIL t2_idx_last got idx %0d last %b exp %0d/0", out_idx_s, out_last_s, i); end
         step();
      end
      stop_s = 1'b1;
      #1;
      checks++; if (out_valid_s !== 1'b1 || out_last_s !== 1'b1) begin errors++; $display("FAIL t2_stop_beat valid %b last %b exp 1/1", out_valid_s, out_last_s); end
      checks++; if (out_idx_s !== 8'd10) begin errors++; $display("FAIL t2_stop_idx got %0d exp 10", out_idx_s); end
      step();
      stop_s = 1'b0;
      #1;
      checks++; if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin errors++; $display("FAIL t2_idle valid %b in_ready %b exp 0/1", out_valid_s, in_ready_s); end
   endtask

   task automatic test_stall();
      int fires = 0;
      int cyc = 0;
      out_ready_s = 1'b0;
      offer(8'd5, 8'd4);
      step();
      in_valid_s = 1'b0;
      while (out_valid_s === 1'b1 && cyc < 20) begin
         out_ready_s = cyc[0];
         #1;
         checks++; if (out_value_s !== 8'd5 || out_idx_s !== 8'(fires)) begin errors++; $display("FAIL t3_hold cyc %0d value %0d idx %0d exp 5/%0d", cyc, out_value_s, out_idx_s, fires); end
         checks++; if (out_last_s !== (fires == 3)) begin errors++; $display("FAIL t3_last cyc %0d got %b exp %b", cyc, out_last_s, (fires == 3)); end
         if (out_ready_s) fires++;
         cyc++;
         step();
      end
      checks++; if (fires != 4 || out_valid_s !== 1'b0) begin errors++; $display("FAIL t3_fire_count got %0d valid %b exp 4/0", fires, out_valid_s); end
   endtask

   task automatic test_back_to_back();
      out_ready_s = 1'b1;
      offer(8'd9, 8'd2);
      step();
      in_valid_s = 1'b0;
      #1;
      checks++; if (out_value_s !== 8'd9 || out_idx_s !== 8'd0 || out_last_s !== 1'b0) begin errors++; $display("FAIL t4_b0 value %0d idx %0d last %b exp 9/0/0", out_value_s, out_idx_s, out_last_s); end
      checks++; if (in_ready_s !== 1'b0) begin errors++; $display("FAIL t4_busy_in_ready got %b exp 0", in_ready_s); end
      step();
      offer(8'd3, 8'd2);
      #1;
      checks++; if (out_value_s !== 8'd9 || out_idx_s !== 8'd1 || out_last_s !== 1'b1) begin errors++; $display("FAIL t4_b1 value %0d idx %0d last %b exp 9/1/1", out_value_s, out_idx_s, out_last_s); end
      checks++; if (in_ready_s !== 1'b1) begin errors++; $display("FAIL t4_end_in_ready got %b exp 1", in_ready_s); end
      step();
      in_valid_s = 1'b0;
      #1;
      checks++; if (out_valid_s !== 1'b1 || out_value_s !== 8'd3 || out_idx_s !== 8'd0 || out_last_s !== 1'b0) begin errors++; $display("FAIL t4_b2 valid %b value %0d idx %0d last %b exp 1/3/0/0", out_valid_s, out_value_s, out_idx_s, out_last_s); end
      step();
      checks++; if (out_valid_s !== 1'b1 || out_value_s !== 8'd3 || out_idx_s !== 8'd1 || out_last_s !== 1'b1) begin errors++; $display("FAIL t4_b3 valid %b value %0d idx %0d last %b exp 1/3/1/1", out_valid_s, out_value_s, out_idx_s, out_last_s); end
      step();
      checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL t4_done_valid got %b exp 0", out_valid_s); end
   endtask

   task automatic test_reset_mid_stream();
      out_ready_s = 1'b1;
      offer(8'd1, 8'd5);
      step();
      in_valid_s = 1'b0;
      step(); step();
      checks++; if (out_valid_s !== 1'b1 || out_idx_s !== 8'd2) begin errors++; $display("FAIL t5_pre valid %b idx %0d exp 1/2", out_valid_s, out_idx_s); end
      rst_s = 1'b1;
      #1;
      checks++; if (in_ready_s !== 1'b0) begin errors++; $display("FAIL t5_rst_in_ready got %b exp 0", in_ready_s); end
      step();
      rst_s = 1'b0;
      #1;
      checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL t5_abandon_valid got %b exp 0", out_valid_s); end
      checks++; if (in_ready_s !== 1'b1) begin errors++; $display("FAIL t5_release_in_ready got %b exp 1", in_ready_s); end
      for (int i = 0; i < 6; i++) begin
         step();
         checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL t5_no_beats cyc %0d got %b exp 0", i, out_valid_s); end
      end
   endtask

   task automatic test_max_count();
      out_ready_s = 1'b1;
      offer(8'hAA, 8'd255);
      step();
      in_valid_s = 1'b0;
      for (int i = 0; i < 255; i++) begin
         checks++; if (out_valid_s !== 1'b1 || out_idx_s !== 8'(i) || out_last_s !== (i == 254)) begin errors++; $display("FAIL max_beat %0d valid %b idx %0d last %b", i, out_valid_s, out_idx_s, out_last_s); end
         step();
      end
      checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL max_done_valid got %b exp 0", out_valid_s); end
   endtask

   task automatic test_inf_wrap();
      out_ready_s = 1'b1;
      offer(8'd3, 8'd0);
      step();
      in_valid_s = 1'b0;
      for (int i = 0; i < 258; i++) begin
         checks++; if (out_valid_s !== 1'b1 || out_idx_s !== 8'(i % 256) || out_last_s !== 1'b0) begin errors++; $display("FAIL wrap_beat %0d valid %b idx %0d last %b exp idx %0d", i, out_valid_s, out_idx_s, out_last_s, i % 256); end
         step();
      end
      stop_s = 1'b1;
      step();
      stop_s = 1'b0;
      checks++; if (out_valid_s !== 1'b0) begin errors++; $display("FAIL wrap_stop_valid got %b exp 0", out_valid_s); end
   endtask

   task automatic test_empty_stream();
      out_ready_s = 1'b1;
      offer(8'd99, 8'd0);
      #1;
      checks++; if (in_ready0_s !== 1'b1) begin errors++; $display("FAIL t6_in_ready_offer got %b exp 1", in_ready0_s); end
      step();
      in_valid_s = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_valid0_s !== 1'b0 || in_ready0_s !== 1'b1) begin errors++; $display("FAIL t6_empty cyc %0d valid %b in_ready %b exp 0/1", i, out_valid0_s, in_ready0_s); end
         step();
      end
      offer(8'd4, 8'd1);
      step();
      in_valid_s = 1'b0;
      #1;
      checks++; if (out_valid0_s !== 1'b1 || out_value0_s !== 8'd4 || out_last0_s !== 1'b1 || out_idx0_s !== 8'd0) begin errors++; $display("FAIL t6_single valid %b value %0d last %b idx %0d exp 1/4/1/0", out_valid0_s, out_value0_s, out_last0_s, out_idx0_s); end
      step();
      checks++; if (out_valid0_s !== 1'b0) begin errors++; $display("FAIL t6_done_valid got %b exp 0", out_valid0_s); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_infinite_stop();
      test_stall();
      test_back_to_back();
      test_reset_mid_stream();
      do_reset();
      test_max_count();
      test_inf_wrap();
      do_reset();
      test_empty_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
